// File: rtl/dec_rr_arbiter_pkg.sv
// dec_arb_pkg: shared types and constants for the decoder arbiter.
// States, decoder enable encodings and requester sizing.
package dec_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_t;

  // Decoder enable pins {G1, G2A, G2B}
  typedef struct packed {
    logic g1;
    logic g2a;
    logic g2b;
  } dec_en_t;

  localparam dec_en_t EN_ON  = dec_en_t'(3'b100);
  localparam dec_en_t EN_OFF = dec_en_t'(3'b011);

endpackage

// File: rtl/dec_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Returns the first set request at or above ptr, wrapping.
module rr_pick
  import dec_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  // Scan offsets high to low so the nearest one to ptr wins last
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        any = 1'b1;
        idx = ptr + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: round-robin arbiter driving a 3-to-8 decoder.
// DEC_ARB_FIXED_PRIO_EN selects lowest-index-wins priority.
module dec_rr_arbiter
  import dec_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               G1,
  output logic               G2A,
  output logic               G2B,
  output logic               gnt_valid,
  output logic [SEL_W-1:0]   gnt_id,
  output logic               busy
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [HW-1:0]    hold_q, hold_d;
  dec_en_t          en_q, en_d;
  logic             gv_q, gv_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

`ifdef DEC_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  assign pick_ptr = ptr_q;
`endif

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // State and output registers; select is latched while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      en_q    <= EN_OFF;
      gv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
      gv_q    <= gv_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: arbitrate in IDLE/GAP, release on drop or hold limit
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!req[sel_q] || hold_q == HOLD_LAST) begin
          state_d = GAP;
`ifndef DEC_ARB_FIXED_PRIO_EN
          ptr_d   = sel_q + 1'b1;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the current state one cycle later
  always_comb begin
    en_d   = EN_OFF;
    gv_d   = 1'b0;
    busy_d = (state_q != IDLE);
    if (state_q == GRANT) begin
      en_d = EN_ON;
      gv_d = 1'b1;
    end
  end

  assign {C, B, A}       = sel_q;
  assign gnt_id          = sel_q;
  assign {G1, G2A, G2B}  = en_q;
  assign gnt_valid       = gv_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// tb_dec_rr_arbiter: model-checked bench for dec_rr_arbiter.
// Decoder Y_ is reconstructed from the arbiter pins.
module tb_dec_rr_arbiter;

  localparam int HOLD = 4;
  localparam int P_IDLE  = 0;
  localparam int P_GRANT = 1;
  localparam int P_GAP   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       A, B, C, G1, G2A, G2B;
  logic       gnt_valid, busy;
  logic [2:0] gnt_id;
  logic [7:0] y_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int m_phase = P_IDLE;
  int m_owner = 0;
  int m_held  = 0;
  int m_ptr   = 0;
  bit e_en    = 1'b0;
  bit e_busy  = 1'b0;

  always #5 clk = ~clk;

  dec_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .A         (A),
    .B         (B),
    .C         (C),
    .G1        (G1),
    .G2A       (G2A),
    .G2B       (G2B),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  function automatic logic [7:0] dec_y(
    input logic a, input logic b, input logic c,
    input logic g1, input logic g2a, input logic g2b);
    if (g1 && !g2a && !g2b) return ~(8'h01 << {c, b, a});
    return 8'hFF;
  endfunction

  assign y_n = dec_y(A, B, C, G1, G2A, G2B);

  function automatic int winner(input logic [7:0] r, input int p);
    int s;
`ifdef DEC_ARB_FIXED_PRIO_EN
    s = 0;
`else
    s = p;
`endif
    for (int o = 0; o < 8; o++)
      if (r[(s + o) % 8]) return (s + o) % 8;
    return -1;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: grant lifetime counted in whole cycles
  always @(posedge clk) begin : model
    automatic int w;
    if (rst) begin
      m_phase <= P_IDLE;
      m_owner <= 0;
      m_held  <= 0;
      m_ptr   <= 0;
      e_en    <= 1'b0;
      e_busy  <= 1'b0;
    end else begin
      e_en   <= (m_phase == P_GRANT);
      e_busy <= (m_phase != P_IDLE);
      if (m_phase == P_GRANT) begin
        if (!req[m_owner] || m_held == HOLD) begin
          m_phase <= P_GAP;
          m_ptr   <= (m_owner + 1) % 8;
        end else begin
          m_held <= m_held + 1;
        end
      end else begin
        w = winner(req, m_ptr);
        if (w >= 0) begin
          m_phase <= P_GRANT;
          m_owner <= w;
          m_held  <= 1;
        end else begin
          m_phase <= P_IDLE;
        end
      end
    end
  end

  // Compare DUT pins against the model every cycle
  always @(negedge clk) begin : cmp
    logic [7:0] ey;
    logic [2:0] eo;
    if (chk_en) begin
      eo = m_owner[2:0];
      ey = e_en ? ~(8'h01 << eo) : 8'hFF;
      check("Y_", y_n, ey);
      check("G1", G1, e_en);
      check("G2A", G2A, !e_en);
      check("G2B", G2B, !e_en);
      check("gnt_valid", gnt_valid, e_en);
      check("busy", busy, e_busy);
      check("gnt_id", gnt_id, eo);
      check("CBA", {C, B, A}, eo);
      check("one_hot", ($countones(~y_n) <= 1), 1);
    end
  end

  task automatic cyc(input logic r, input logic [7:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

`ifdef DEC_ARB_FIXED_PRIO_EN
  logic [7:0] exp_c [12] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE,
                             8'hFE, 8'hFF, 8'hFE, 8'hFE,
                             8'hFE, 8'hFE, 8'hFF, 8'hFE};
  logic [7:0] exp_after_rst = 8'hFD;
`else
  logic [7:0] exp_c [12] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE,
                             8'hFE, 8'hFF, 8'h7F, 8'h7F,
                             8'h7F, 8'h7F, 8'hFF, 8'hFE};
  logic [7:0] exp_after_rst = 8'h7F;
`endif
  logic [7:0] exp_h [15] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE,
                             8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE,
                             8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE};

  initial begin
    logic [7:0] rq;
    // Reset with all requests asserted
    cyc(1'b1, 8'hFF);
    cyc(1'b1, 8'hFF);
    chk_en = 1'b1;
    check("rst_Y", y_n, 8'hFF);
    check("rst_G1", G1, 1'b0);
    check("rst_G2", {G2A, G2B}, 2'b11);
    check("rst_gv", gnt_valid, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Single request to 2
    cyc(1'b0, 8'h04);
    check("single_latency", y_n, 8'hFF);
    cyc(1'b0, 8'h04);
    check("single_Y", y_n, 8'hFB);
    check("single_CBA", {C, B, A}, 3'b010);
    check("single_gv", gnt_valid, 1'b1);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    check("single_gap_Y", y_n, 8'hFF);
    check("single_gap_busy", busy, 1'b1);
    cyc(1'b0, 8'h00);
    check("single_idle_busy", busy, 1'b0);

    // Contention between 0 and 7
    cyc(1'b1, 8'h00);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 8'h81);
      check($sformatf("contend[%0d]", i), y_n, exp_c[i]);
    end

    // Sole hog on index 0
    cyc(1'b1, 8'h00);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 8'h01);
      check($sformatf("hog[%0d]", i), y_n, exp_h[i]);
    end

    // Reset in the middle of a grant to 5
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h20);
    cyc(1'b0, 8'h20);
    cyc(1'b0, 8'h20);
    check("g5_Y", y_n, 8'hDF);
    cyc(1'b1, 8'h20);
    check("midrst_Y", y_n, 8'hFF);
    check("midrst_busy", busy, 1'b0);
    cyc(1'b0, 8'h82);
    cyc(1'b0, 8'h82);
    check("after_rst_first", y_n, 8'hFD);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h82);
    check("after_rst_gap", y_n, 8'hFF);
    cyc(1'b0, 8'h82);
    check("after_rst_second", y_n, exp_after_rst);

    // Low index drops, higher index takes over
    cyc(1'b1, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h81);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h80);

    // Pseudo-random traffic with occasional reset
    rq = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if (i % 3 == 0) rq = 8'($urandom_range(0, 255));
      cyc($urandom_range(0, 39) == 0, rq);
    end

    cyc(1'b0, 8'h00);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
